// File: rtl/segment_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package segment_pkg;

    typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} scan_state_t;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [7:0] CHAR_DASH = 8'h24;

endpackage

// File: rtl/segment_ram_txt.sv
// Text character table: character code -> active-low segments {g,f,e,d,c,b,a}.
// Codes 0x00-0x0F are hex digits, 0x10-0x23 letters, 0x24 is '-', anything above is blank.
module segment_ram_txt
    import segment_pkg::*;
(
    input  logic [7:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_code)
            8'h00: o_seg = 7'h40;
            8'h01: o_seg = 7'h79;
            8'h02: o_seg = 7'h24;
            8'h03: o_seg = 7'h30;
            8'h04: o_seg = 7'h19;
            8'h05: o_seg = 7'h12;
            8'h06: o_seg = 7'h02;
            8'h07: o_seg = 7'h78;
            8'h08: o_seg = 7'h00;
            8'h09: o_seg = 7'h10;
            8'h0A: o_seg = 7'h08;
            8'h0B: o_seg = 7'h03;
            8'h0C: o_seg = 7'h46;
            8'h0D: o_seg = 7'h21;
            8'h0E: o_seg = 7'h06;
            8'h0F: o_seg = 7'h0E;
            // Letters that have no clean 7-segment form use the nearest readable shape.
            8'h10: o_seg = 7'h42;
            8'h11: o_seg = 7'h09;
            8'h12: o_seg = 7'h79;
            8'h13: o_seg = 7'h61;
            8'h14: o_seg = 7'h0A;
            8'h15: o_seg = 7'h47;
            8'h16: o_seg = 7'h48;
            8'h17: o_seg = 7'h2B;
            8'h18: o_seg = 7'h23;
            8'h19: o_seg = 7'h0C;
            8'h1A: o_seg = 7'h18;
            8'h1B: o_seg = 7'h2F;
            8'h1C: o_seg = 7'h12;
            8'h1D: o_seg = 7'h07;
            8'h1E: o_seg = 7'h41;
            8'h1F: o_seg = 7'h63;
            8'h20: o_seg = 7'h55;
            8'h21: o_seg = 7'h09;
            8'h22: o_seg = 7'h11;
            8'h23: o_seg = 7'h24;
            8'h24: o_seg = 7'h3F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/segment_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Optional SEGMENT_BLINK_EN adds per-digit blinking via i_blink.
//   state   | meaning
//   S_BLANK | first BLANK_CYC cycles of a slot, all anodes off
//   S_DRIVE | rest of the slot, anode idx on, segments from snapshot code
module segment_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1_000,
    parameter int BLANK_CYC = 64,
    parameter int BLINK_HZ  = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic                        i_we,
    input  logic [$clog2(DIGITS)-1:0]   i_addr,
    input  logic [7:0]                  i_data,
    input  logic                        i_dp,
`ifdef SEGMENT_BLINK_EN
    input  logic [DIGITS-1:0]           i_blink,
`endif
    output logic [DIGITS-1:0]           o_an,
    output logic [6:0]                  o_seg,
    output logic                        o_dp,
    output logic                        o_frame
);
    import segment_pkg::*;

    localparam int PERIOD = CLK_HZ / SCAN_HZ;
    localparam int CW     = $clog2(PERIOD);
    localparam int AW     = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [AW-1:0] IDX_LAST   = AW'(DIGITS - 1);

    if (PERIOD < BLANK_CYC + 2) begin : g_bad_period
        $error("segment_scan_ctrl: PERIOD %0d shorter than BLANK_CYC+2", PERIOD);
    end

    logic addr_ok;
    if (DIGITS == (1 << AW)) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_part
        assign addr_ok = ({1'b0, i_addr} < (AW + 1)'(DIGITS));
    end

    scan_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [7:0]        chr_q [DIGITS];
    logic [7:0]        chr_d [DIGITS];
    logic [DIGITS-1:0] dpm_q, dpm_d;
    logic [7:0]        code_q, code_d;
    logic              dps_q, dps_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dpo_q, dpo_d;
    logic [7:0]        snap_code;
    logic              snap_dp;
    logic [6:0]        tbl_seg;

`ifdef SEGMENT_BLINK_EN
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (i_en) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end
`endif

    // A snapshot reads the registered buffer, so a same-cycle write lands one slot later.
    assign snap_code = (cnt_q == '0) ? chr_q[idx_q] : code_q;
    assign snap_dp   = (cnt_q == '0) ? dpm_q[idx_q] : dps_q;

    segment_ram_txt u_txt (
        .i_code (snap_code),
        .o_seg  (tbl_seg)
    );

    always_comb begin
        chr_d = chr_q;
        dpm_d = dpm_q;
        if (i_we && addr_ok) begin
            chr_d[i_addr] = i_data;
            dpm_d[i_addr] = i_dp;
        end

        code_d  = snap_code;
        dps_d   = snap_dp;
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;

        if (!i_en) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                S_BLANK: if (cnt_q == BLANK_LAST) state_d = S_DRIVE;
                S_DRIVE: if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + AW'(1);
                    state_d = S_BLANK;
                end
            endcase
        end

        an_d  = '1;
        seg_d = SEG_OFF;
        dpo_d = 1'b1;
        if (state_d == S_DRIVE) begin
            an_d[idx_d] = 1'b0;
            seg_d       = tbl_seg;
            dpo_d       = ~snap_dp;
`ifdef SEGMENT_BLINK_EN
            if (!phase_q && i_blink[idx_d]) begin
                seg_d = SEG_OFF;
                dpo_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            chr_q   <= '{default: CHAR_DASH};
            dpm_q   <= '0;
            code_q  <= CHAR_DASH;
            dps_q   <= 1'b0;
            an_q    <= '1;
            seg_q   <= SEG_OFF;
            dpo_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            chr_q   <= chr_d;
            dpm_q   <= dpm_d;
            code_q  <= code_d;
            dps_q   <= dps_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dpo_q   <= dpo_d;
        end
    end

    assign o_an    = an_q;
    assign o_seg   = seg_q;
    assign o_dp    = dpo_q;
    assign o_frame = i_en && (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Directed bench for segment_scan_ctrl: DIGITS=4, PERIOD=10, BLANK_CYC=2.
module tb_segment_scan_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst, i_en, i_we, i_dp;
    logic [1:0] i_addr;
    logic [7:0] i_data;
    logic [3:0] i_blink = 4'b0000;
    logic [3:0] o_an;
    logic [6:0] o_seg;
    logic       o_dp, o_frame;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    segment_scan_ctrl #(
        .DIGITS    (4),
        .CLK_HZ    (1000),
        .SCAN_HZ   (100),
        .BLANK_CYC (2),
        .BLINK_HZ  (50)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_we    (i_we),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .i_dp    (i_dp),
`ifdef SEGMENT_BLINK_EN
        .i_blink (i_blink),
`endif
        .o_an    (o_an),
        .o_seg   (o_seg),
        .o_dp    (o_dp),
        .o_frame (o_frame)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic p);
        i_we = 1'b1; i_addr = a; i_data = d; i_dp = p;
        tick();
        i_we = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " an"},    8'(o_an),    8'h0F);
        chk({tag, " seg"},   8'(o_seg),   8'h7F);
        chk({tag, " dp"},    8'(o_dp),    8'h01);
        chk({tag, " frame"}, 8'(o_frame), 8'h00);
    endtask

    // Walk one full slot from cnt=0: 2 blank cycles then 8 drive cycles on digit d.
    task automatic scan_slot(input int d, input logic [6:0] seg, input logic dp);
        logic [3:0] ea;
        for (int c = 0; c < 10; c++) begin
            ea = 4'hF;
            if (c >= 2) ea[d] = 1'b0;
            chk($sformatf("an d%0d c%0d", d, c),    8'(o_an),    8'(ea));
            chk($sformatf("seg d%0d c%0d", d, c),   8'(o_seg),   (c >= 2) ? 8'(seg) : 8'h7F);
            chk($sformatf("dp d%0d c%0d", d, c),    8'(o_dp),    (c >= 2 && dp) ? 8'h00 : 8'h01);
            chk($sformatf("frame d%0d c%0d", d, c), 8'(o_frame), (d == 3 && c == 9) ? 8'h01 : 8'h00);
            tick();
            i_we = 1'b0;
        end
    endtask

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_we = 1'b0; i_addr = 2'd0; i_data = 8'h00; i_dp = 1'b0;
        tick();
        tick();
        check_idle("reset");

        // 1: default buffer shows '-' on every digit
        i_rst = 1'b0;
        i_en  = 1'b1;
        scan_slot(0, 7'h3F, 1'b0);
        scan_slot(1, 7'h3F, 1'b0);
        scan_slot(2, 7'h3F, 1'b0);
        scan_slot(3, 7'h3F, 1'b0);

        // 2: load A b C d with DP on digit 2, written while dark
        i_en = 1'b0;
        wr(2'd0, 8'h0A, 1'b0);
        check_idle("dark");
        wr(2'd1, 8'h0B, 1'b0);
        wr(2'd2, 8'h0C, 1'b1);
        wr(2'd3, 8'h0D, 1'b0);
        i_en = 1'b1;
        scan_slot(0, 7'h08, 1'b0);
        scan_slot(1, 7'h03, 1'b0);
        scan_slot(2, 7'h46, 1'b1);
        scan_slot(3, 7'h21, 1'b0);

        // 3: write to the digit being driven; current slot keeps the old code
        scan_slot(0, 7'h08, 1'b0);
        repeat (4) tick();
        wr(2'd1, 8'h05, 1'b0);
        chk("midwrite an",  8'(o_an),  8'h0D);
        chk("midwrite seg", 8'(o_seg), 8'h03);
        repeat (5) tick();
        // write on the snapshot cycle of digit 2: snapshot takes the old value
        i_we = 1'b1; i_addr = 2'd2; i_data = 8'h0E; i_dp = 1'b0;
        scan_slot(2, 7'h46, 1'b1);
        scan_slot(3, 7'h21, 1'b0);
        scan_slot(0, 7'h08, 1'b0);
        scan_slot(1, 7'h12, 1'b0);
        scan_slot(2, 7'h06, 1'b0);

        // 4: drop enable mid-drive, resume after 5 cycles
        repeat (3) tick();
        chk("predrop an", 8'(o_an), 8'h07);
        i_en = 1'b0;
        tick();
        check_idle("en drop");
        repeat (4) tick();
        check_idle("en held");
        i_en = 1'b1;
        scan_slot(0, 7'h08, 1'b0);

        // 5: reset mid-slot restores '-' and clears DP bits
        repeat (4) tick();
        chk("prerst an", 8'(o_an), 8'h0D);
        i_rst = 1'b1;
        tick();
        check_idle("midrst");
        i_rst = 1'b0;
        scan_slot(0, 7'h3F, 1'b0);
        scan_slot(1, 7'h3F, 1'b0);
        scan_slot(2, 7'h3F, 1'b0);
        scan_slot(3, 7'h3F, 1'b0);

        // codes around the end of the table
        i_en = 1'b0;
        wr(2'd0, 8'h25, 1'b0);
        wr(2'd1, 8'hFF, 1'b1);
        wr(2'd2, 8'h24, 1'b0);
        wr(2'd3, 8'h00, 1'b0);
        i_en = 1'b1;
        scan_slot(0, 7'h7F, 1'b0);
        scan_slot(1, 7'h7F, 1'b1);
        scan_slot(2, 7'h3F, 1'b0);
        scan_slot(3, 7'h40, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
